alu_issue_ctrl: RTL

Sequential issue/writeback controller that drives the combinational ALU. It sits between the instruction source and the ALU. It accepts one 16-bit instruction per handshake and reads operands from an internal 16×16 register file. It then presents opcode/A/B to the ALU, captures the ALU result and flags, and writes the result back. For compare-branch opcodes it reports the branch decision instead of writing back.

---
 rtl/alu_issue_pkg.sv | 49 ++++
 rtl/alu_issue_regfile.sv | 36 +++
 rtl/alu_issue_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg: shared constants, instruction field positions and FSM
// state type for the ALU issue/writeback controller.
package alu_issue_pkg;

    localparam int DATA_W   = 16;
    localparam int OPC_W    = 4;
    localparam int REG_W    = 4;
    localparam int NUM_REGS = 16;

    // Instruction word layout: {opcode, rd, rs, rt}
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 8;
    localparam int RS_MSB  = 7;
    localparam int RS_LSB  = 4;
    localparam int RT_MSB  = 3;
    localparam int RT_LSB  = 0;

    localparam logic [OPC_W-1:0] OP_ADD     = 4'd0;
    localparam logic [OPC_W-1:0] OP_SHL     = 4'd1;
    localparam logic [OPC_W-1:0] OP_SHR     = 4'd2;
    localparam logic [OPC_W-1:0] OP_OR      = 4'd3;
    localparam logic [OPC_W-1:0] OP_AND     = 4'd4;
    localparam logic [OPC_W-1:0] OP_ADDI_LO = 4'd5;
    localparam logic [OPC_W-1:0] OP_ADDI_HI = 4'd9;
    localparam logic [OPC_W-1:0] OP_BEQ     = 4'd10;
    localparam logic [OPC_W-1:0] OP_BNE     = 4'd11;
    localparam logic [OPC_W-1:0] OP_MFHI    = 4'd12;
    localparam logic [OPC_W-1:0] OP_MUL     = 4'd13;
    localparam logic [OPC_W-1:0] OP_MFLO    = 4'd14;
    localparam logic [OPC_W-1:0] OP_SUB     = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    function automatic logic is_branch(input logic [OPC_W-1:0] op);
        return (op == OP_BEQ) || (op == OP_BNE);
    endfunction

    function automatic logic is_imm(input logic [OPC_W-1:0] op);
        return (op >= OP_ADDI_LO) && (op <= OP_ADDI_HI);
    endfunction

endpackage

// File: rtl/alu_issue_regfile.sv
// alu_issue_regfile: 16x16 register file.
// Ports: clk_i/reset_i (sync, active-high clear), two combinational read
// ports (ra/rb), one combinational debug read port, one synchronous write
// port (we_i/wa_i/wd_i). Writes to R0 are dropped so R0 always reads 0.
module alu_issue_regfile
    import alu_issue_pkg::*;
(
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [REG_W-1:0]  ra_addr_i,
    output logic [DATA_W-1:0] ra_data_o,
    input  logic [REG_W-1:0]  rb_addr_i,
    output logic [DATA_W-1:0] rb_data_o,
    input  logic [REG_W-1:0]  dbg_addr_i,
    output logic [DATA_W-1:0] dbg_data_o,
    input  logic              we_i,
    input  logic [REG_W-1:0]  wa_i,
    input  logic [DATA_W-1:0] wd_i
);

    logic [NUM_REGS-1:0][DATA_W-1:0] regs_q;

    // Reset has priority, so a write coinciding with reset is lost.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            regs_q <= '0;
        end else if (we_i && (wa_i != '0)) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    assign ra_data_o  = regs_q[ra_addr_i];
    assign rb_data_o  = regs_q[rb_addr_i];
    assign dbg_data_o = regs_q[dbg_addr_i];

endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issue/writeback controller for an external combinational
// ALU. Accepts one instruction per handshake (instr_valid/instr_ready),
// presents registered opcode/operands on alu_*, captures alu_out and flags
// into result/flag_*, writes back to the register file, and reports
// branch decisions for BEQ/BNE via branch_valid/branch_taken with the
// one-cycle done pulse. dbg_addr/dbg_data give a combinational register peek.
module alu_issue_ctrl
    import alu_issue_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [15:0]       instr,
    output logic [OPC_W-1:0]  alu_opcode,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_zero,
    input  logic              alu_neg,
    input  logic              alu_ovf,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              flag_zero,
    output logic              flag_neg,
    output logic              flag_ovf,
    output logic              branch_valid,
    output logic              branch_taken,
    input  logic [REG_W-1:0]  dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    state_e              state_q, state_d;
    logic [OPC_W-1:0]    op_q;
    logic [REG_W-1:0]    rd_q;
    logic [OPC_W-1:0]    alu_opcode_q, alu_opcode_d;
    logic [DATA_W-1:0]   alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [DATA_W-1:0]   result_q;
    logic                flag_zero_q, flag_neg_q, flag_ovf_q, branch_taken_q;

    logic [OPC_W-1:0]    op_in;
    logic [REG_W-1:0]    rd_in, rs_in, rt_in;
    logic [REG_W-1:0]    ra_addr, rb_addr;
    logic [DATA_W-1:0]   ra_data, rb_data;
    logic                accept, capture, wb_en;

    assign op_in = instr[OPC_MSB:OPC_LSB];
    assign rd_in = instr[RD_MSB:RD_LSB];
    assign rs_in = instr[RS_MSB:RS_LSB];
    assign rt_in = instr[RT_MSB:RT_LSB];

    // Branches compare R[rd] against R[rs]; everything else reads rs/rt.
    assign ra_addr = is_branch(op_in) ? rd_in : rs_in;
    assign rb_addr = is_branch(op_in) ? rs_in : rt_in;

    assign instr_ready = (state_q == ST_IDLE) && !reset;
    assign accept      = instr_valid && instr_ready;
    assign capture     = (state_q == ST_CAPTURE);
    assign wb_en       = capture && !is_branch(op_q);

    alu_issue_regfile u_regfile (
        .clk_i      (clk),
        .reset_i    (reset),
        .ra_addr_i  (ra_addr),
        .ra_data_o  (ra_data),
        .rb_addr_i  (rb_addr),
        .rb_data_o  (rb_data),
        .dbg_addr_i (dbg_addr),
        .dbg_data_o (dbg_data),
        .we_i       (wb_en),
        .wa_i       (rd_q),
        .wd_i       (alu_out)
    );

    always_comb begin
        state_d      = state_q;
        alu_opcode_d = alu_opcode_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d      = ST_ISSUE;
                    alu_opcode_d = is_branch(op_in) ? OP_SUB : op_in;
                    alu_a_d      = ra_data;
                    alu_b_d      = is_imm(op_in) ? {{(DATA_W-REG_W){1'b0}}, rt_in} : rb_data;
                end
            end
            ST_ISSUE:   state_d = ST_CAPTURE;
            ST_CAPTURE: state_d = ST_DONE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            op_q           <= '0;
            rd_q           <= '0;
            alu_opcode_q   <= '0;
            alu_a_q        <= '0;
            alu_b_q        <= '0;
            result_q       <= '0;
            flag_zero_q    <= 1'b0;
            flag_neg_q     <= 1'b0;
            flag_ovf_q     <= 1'b0;
            branch_taken_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            alu_opcode_q <= alu_opcode_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            if (accept) begin
                op_q <= op_in;
                rd_q <= rd_in;
            end
            if (capture) begin
                result_q       <= alu_out;
                flag_zero_q    <= alu_zero;
                flag_neg_q     <= alu_neg;
                flag_ovf_q     <= alu_ovf;
                branch_taken_q <= (op_q == OP_BEQ) ? alu_zero :
                                  (op_q == OP_BNE) ? ~alu_zero : 1'b0;
            end
        end
    end

    assign alu_opcode   = alu_opcode_q;
    assign alu_a        = alu_a_q;
    assign alu_b        = alu_b_q;
    assign result       = result_q;
    assign flag_zero    = flag_zero_q;
    assign flag_neg     = flag_neg_q;
    assign flag_ovf     = flag_ovf_q;
    assign branch_taken = branch_taken_q;
    assign done         = (state_q == ST_DONE);
    assign branch_valid = done && is_branch(op_q);

endmodule
